// File: rtl/palu_issue.sv
// palu_issue: instruction issue stage in front of the palu pipeline.
// Buffers instructions in a DEPTH-entry FIFO and presents at most one per cycle.
// It inserts a one-cycle bubble when the head reads the destination of the
// instruction presented in the previous cycle, because that result cannot be
// bypassed yet. It also keeps a saturating count of hazard-stall cycles.
// Optional feature macro: PALU_ISSUE_OPCODE_AWARE_EN. When it is defined, hazard
// detection uses per-opcode source usage. Otherwise every opcode is treated as
// reading both sources, which gives conservative stalls.
module palu_issue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [1:0]       in_src1,
    input  logic [1:0]       in_src2,
    input  logic [1:0]       in_dest,
    output logic             stall,
    output logic [2:0]       opcode,
    output logic [1:0]       src1,
    output logic [1:0]       src2,
    output logic [1:0]       dest,
    output logic             empty,
    output logic [CNT_W-1:0] stall_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

`ifdef PALU_ISSUE_OPCODE_AWARE_EN
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_ONE  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
`endif

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] src1;
        logic [1:0] src2;
        logic [1:0] dest;
    } instr_t;

    instr_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    instr_t           head;
    logic             full;
    logic             uses_src1;
    logic             uses_src2;
    logic             hazard;
    logic             push;
    logic             pop;

    // Occupancy flags come from the registered count only.
    always_comb begin
        full     = (count == (PTR_W+1)'(DEPTH));
        empty    = (count == '0);
        in_ready = !full;
        head     = mem[rd_ptr];
    end

    // Work out which sources the head opcode reads.
    always_comb begin
`ifdef PALU_ISSUE_OPCODE_AWARE_EN
        uses_src1 = (head.opcode != OP_ONE);
        uses_src2 = (head.opcode == OP_ADD) || (head.opcode == OP_SUB) ||
                    (head.opcode == OP_AND) || (head.opcode == OP_NAND);
`else
        uses_src1 = 1'b1;
        uses_src2 = 1'b1;
`endif
    end

    // The head must wait one cycle when it reads the result still in Ex. After a
    // bubble (stall=1), that result can be forwarded, so the head never waits twice.
    always_comb begin
        hazard = !stall && !empty && (uses_src1 || uses_src2) &&
                 ((head.src1 == dest) || (uses_src2 && (head.src2 == dest)));
        pop    = !empty && !hazard;
        push   = in_valid && !full;
    end

    // FIFO storage. Stale entries are never visible because pointers and count
    // gate every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= '{opcode: in_opcode, src1: in_src1, src2: in_src2, dest: in_dest};
        end
    end

    // Pointers, occupancy, presented instruction and stall counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            stall       <= 1'b1;
            opcode      <= '0;
            src1        <= '0;
            src2        <= '0;
            dest        <= '0;
            stall_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                stall  <= 1'b0;
                opcode <= head.opcode;
                src1   <= head.src1;
                src2   <= head.src2;
                dest   <= head.dest;
            end else begin
                stall <= 1'b1;
            end
            if (hazard && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule
